// File: rtl/smoldvi_pkg.sv
// smoldvi_pkg: shared definitions for the smoldvi video core.
//   - TMDS control-period symbols (CTRL_00..CTRL_11, indexed by c = {c1, c0})
//   - raster_t: den/hsync/vsync bundle carried down the alignment delay line
//   - run_state_t: raster enable state
//   - widen8():    MSB-replicating widening of an N-bit channel to 8 bits
//   - cnt_w():     $clog2-based counter width, never smaller than 1
package smoldvi_pkg;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  // sync fields hold the pin level, polarity already applied
  typedef struct packed {
    logic den;
    logic hsync;
    logic vsync;
  } raster_t;

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    case (c)
      2'b00:   return CTRL_00;
      2'b01:   return CTRL_01;
      2'b10:   return CTRL_10;
      default: return CTRL_11;
    endcase
  endfunction

  // d holds the channel in its low 'bits' bits; the pattern repeats MSB-first
  function automatic logic [7:0] widen8(input logic [7:0] d, input int unsigned bits);
    logic [7:0]  o;
    int unsigned idx;
    o = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = bits - 1 - (i % bits);
      o[3'(7 - i)] = d[3'(idx)];
    end
    return o;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/smoldvi_tmds_encode_pipe.sv
// smoldvi_tmds_encode_pipe: two-stage TMDS encoder for one DVI channel.
//   Stage 1 registers the transition-minimised word q_m[8:0] with den/ctrl.
//   Stage 2 applies DC balancing (running disparity) or emits a control code.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_d[7:0]       pixel byte
//   i_den          data enable (1 = pixel, 0 = control period)
//   i_ctrl[1:0]    control bits {c1, c0} used when i_den is low
//   o_tmds[9:0]    encoded symbol, bit 0 transmitted first
module smoldvi_tmds_encode_pipe
  import smoldvi_pkg::*;
#(
  parameter logic [1:0] RST_CTRL = 2'b00
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_d,
  input  logic       i_den,
  input  logic [1:0] i_ctrl,
  output logic [9:0] o_tmds
);

  logic [8:0]        r_qm;
  logic              r_den;
  logic [1:0]        r_ctrl;
  logic signed [4:0] r_cnt;

  logic [3:0]        w_n1;
  logic              w_xnor;
  logic [8:0]        w_qm;
  logic [3:0]        w_n1q;
  logic signed [4:0] w_bal;
  logic [9:0]        w_sym;
  logic signed [4:0] w_cnt_nxt;

  // Stage 1: transition minimisation
  always_comb begin
    w_n1 = '0;
    for (int i = 0; i < 8; i++) w_n1 = w_n1 + 4'(i_d[i]);
    w_xnor  = (w_n1 > 4'd4) || ((w_n1 == 4'd4) && !i_d[0]);
    w_qm    = '0;
    w_qm[0] = i_d[0];
    for (int i = 1; i < 8; i++)
      w_qm[i] = w_xnor ? ~(w_qm[i-1] ^ i_d[i]) : (w_qm[i-1] ^ i_d[i]);
    w_qm[8] = ~w_xnor;
  end

  // Stage 2: DC balance; w_bal = ones - zeros of q_m[7:0]
  always_comb begin
    w_n1q = '0;
    for (int i = 0; i < 8; i++) w_n1q = w_n1q + 4'(r_qm[i]);
    w_bal     = $signed(5'({w_n1q, 1'b0})) - 5'sd8;
    w_sym     = ctrl_code(r_ctrl);
    w_cnt_nxt = '0;
    if (r_den) begin
      if ((r_cnt == 0) || (w_bal == 0)) begin
        w_sym     = {~r_qm[8], r_qm[8], (r_qm[8] ? r_qm[7:0] : ~r_qm[7:0])};
        w_cnt_nxt = r_qm[8] ? (r_cnt + w_bal) : (r_cnt - w_bal);
      end else if ((!r_cnt[4] && (w_bal > 0)) || (r_cnt[4] && (w_bal < 0))) begin
        // r_cnt is non-zero here, so its sign bit alone decides > 0 vs < 0
        w_sym     = {1'b1, r_qm[8], ~r_qm[7:0]};
        w_cnt_nxt = r_cnt + (r_qm[8] ? 5'sd2 : 5'sd0) - w_bal;
      end else begin
        w_sym     = {1'b0, r_qm[8], r_qm[7:0]};
        w_cnt_nxt = r_cnt - (r_qm[8] ? 5'sd0 : 5'sd2) + w_bal;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_qm   <= '0;
      r_den  <= 1'b0;
      r_ctrl <= RST_CTRL;
      r_cnt  <= '0;
      o_tmds <= ctrl_code(RST_CTRL);
    end else begin
      r_qm   <= w_qm;
      r_den  <= i_den;
      r_ctrl <= i_ctrl;
      r_cnt  <= w_cnt_nxt;
      o_tmds <= w_sym;
    end
  end

endmodule

// File: rtl/smoldvi_video_core.sv
// smoldvi_video_core: pixel-clock DVI core. Generates raster timing, requests
// pixels PIX_LATENCY cycles ahead of use, and TMDS-encodes blue/green/red.
// Ports:
//   clk_pix, rst_pix   pixel clock, asynchronous active-high reset
//   en                 raster enable; low parks the counters at (0,0)
//   test_pattern       colour-bar override (only with SMOLDVI_TEST_PATTERN_EN)
//   px_req             high while the counters sit in the active area
//   px_x, px_y         counter position being requested
//   frame_start        one-cycle pulse at position (0,0)
//   r, g, b            pixel data, valid PIX_LATENCY cycles after px_req
//   tmds0/1/2          10-bit symbols for blue/green/red, bit 0 first
// Build option: define SMOLDVI_TEST_PATTERN_EN to add the test_pattern port
// and the 8-bar generator.
module smoldvi_video_core
  import smoldvi_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter logic        HSYNC_POL   = 1'b0,
  parameter logic        VSYNC_POL   = 1'b0,
  parameter int unsigned RGB_BITS    = 8,
  parameter int unsigned PIX_LATENCY = 1,
  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned XW         = cnt_w(H_TOTAL),
  localparam int unsigned YW         = cnt_w(V_TOTAL)
) (
  input  logic                clk_pix,
  input  logic                rst_pix,
  input  logic                en,
`ifdef SMOLDVI_TEST_PATTERN_EN
  input  logic                test_pattern,
`endif
  output logic                px_req,
  output logic [XW-1:0]       px_x,
  output logic [YW-1:0]       px_y,
  output logic                frame_start,
  input  logic [RGB_BITS-1:0] r,
  input  logic [RGB_BITS-1:0] g,
  input  logic [RGB_BITS-1:0] b,
  output logic [9:0]          tmds0,
  output logic [9:0]          tmds1,
  output logic [9:0]          tmds2
);

  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam raster_t     RAS_IDLE     = '{den: 1'b0, hsync: !HSYNC_POL, vsync: !VSYNC_POL};

  run_state_t    r_state, w_state_nxt;
  logic [XW-1:0] r_h, w_h_nxt;
  logic [YW-1:0] r_v, w_v_nxt;
  logic [31:0]   w_hn, w_vn;
  logic          w_act, w_fs;
  raster_t       w_ras0, w_ras_al;
  raster_t       r_ras [PIX_LATENCY+1];
  logic [7:0]    w_r8, w_g8, w_b8;

  // Run state and next counter position; the first enabled cycle issues (0,0)
  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = '0;
    w_v_nxt     = '0;
    w_hn        = '0;
    w_vn        = '0;
    w_act       = 1'b0;
    w_fs        = 1'b0;
    w_ras0      = RAS_IDLE;
    if (!en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      w_state_nxt = ST_RUN;
      if (r_state == ST_RUN) begin
        if (32'(r_h) == H_TOTAL - 1) begin
          w_h_nxt = '0;
          w_v_nxt = (32'(r_v) == V_TOTAL - 1) ? '0 : r_v + YW'(1);
        end else begin
          w_h_nxt = r_h + XW'(1);
          w_v_nxt = r_v;
        end
      end
      w_hn         = 32'(w_h_nxt);
      w_vn         = 32'(w_v_nxt);
      w_act        = (w_hn < H_ACTIVE) && (w_vn < V_ACTIVE);
      w_fs         = (w_hn == 0) && (w_vn == 0);
      w_ras0.den   = w_act;
      w_ras0.hsync = ((w_hn >= H_SYNC_START) && (w_hn < H_SYNC_END)) ? HSYNC_POL : !HSYNC_POL;
      w_ras0.vsync = ((w_vn >= V_SYNC_START) && (w_vn < V_SYNC_END)) ? VSYNC_POL : !VSYNC_POL;
    end
  end

  // Counters, request outputs, and raster delay line (index 0 = request stage)
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      r_state     <= ST_IDLE;
      r_h         <= '0;
      r_v         <= '0;
      px_req      <= 1'b0;
      frame_start <= 1'b0;
      for (int k = 0; k <= int'(PIX_LATENCY); k++) r_ras[k] <= RAS_IDLE;
    end else begin
      r_state     <= w_state_nxt;
      r_h         <= w_h_nxt;
      r_v         <= w_v_nxt;
      px_req      <= w_act;
      frame_start <= w_fs;
      r_ras[0]    <= w_ras0;
      for (int k = 1; k <= int'(PIX_LATENCY); k++) r_ras[k] <= r_ras[k-1];
    end
  end

  assign px_x     = r_h;
  assign px_y     = r_v;
  assign w_ras_al = r_ras[PIX_LATENCY];

`ifdef SMOLDVI_TEST_PATTERN_EN
  logic [2:0] r_bar [PIX_LATENCY+1];
  logic [2:0] w_bar;

  assign w_bar = 3'((w_hn * 32'd8) / H_ACTIVE);

  // Bar index travels with den so it lines up with the pixel data
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      for (int k = 0; k <= int'(PIX_LATENCY); k++) r_bar[k] <= '0;
    end else begin
      r_bar[0] <= w_bar;
      for (int k = 1; k <= int'(PIX_LATENCY); k++) r_bar[k] <= r_bar[k-1];
    end
  end
`endif

  // Channel widening, optionally replaced by colour bars
  always_comb begin
    w_r8 = widen8(8'(r), RGB_BITS);
    w_g8 = widen8(8'(g), RGB_BITS);
    w_b8 = widen8(8'(b), RGB_BITS);
`ifdef SMOLDVI_TEST_PATTERN_EN
    if (test_pattern) begin
      w_r8 = {8{r_bar[PIX_LATENCY][2]}};
      w_g8 = {8{r_bar[PIX_LATENCY][1]}};
      w_b8 = {8{r_bar[PIX_LATENCY][0]}};
    end
`endif
  end

  // Syncs ride on the blue channel only
  smoldvi_tmds_encode_pipe #(.RST_CTRL({!VSYNC_POL, !HSYNC_POL})) u_enc_b (
    .i_clk  (clk_pix),
    .i_rst  (rst_pix),
    .i_d    (w_b8),
    .i_den  (w_ras_al.den),
    .i_ctrl ({w_ras_al.vsync, w_ras_al.hsync}),
    .o_tmds (tmds0)
  );

  smoldvi_tmds_encode_pipe #(.RST_CTRL(2'b00)) u_enc_g (
    .i_clk  (clk_pix),
    .i_rst  (rst_pix),
    .i_d    (w_g8),
    .i_den  (w_ras_al.den),
    .i_ctrl (2'b00),
    .o_tmds (tmds1)
  );

  smoldvi_tmds_encode_pipe #(.RST_CTRL(2'b00)) u_enc_r (
    .i_clk  (clk_pix),
    .i_rst  (rst_pix),
    .i_d    (w_r8),
    .i_den  (w_ras_al.den),
    .i_ctrl (2'b00),
    .o_tmds (tmds2)
  );

endmodule

// File: tb/tb_smoldvi_video_core.sv
// tb_smoldvi_video_core: directed bench on an 8x5 raster (H 4/1/2/1,
// V 2/1/1/1), RGB_BITS=5, PIX_LATENCY=1. One frame of expected symbols is held
// in a table indexed by raster position.
module tb_smoldvi_video_core;

  localparam int unsigned NPOS  = 40;
  localparam logic [9:0]  C00   = 10'b1101010100;
  localparam logic [9:0]  C01   = 10'b0010101011;
  localparam logic [9:0]  C10   = 10'b0101010100;
  localparam logic [9:0]  C11   = 10'b1010101011;
  localparam logic [4:0]  JUNK  = 5'h0A;

  typedef struct {
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
    logic [9:0] e2;
    logic [9:0] e1;
    logic [9:0] e0;
  } vec_t;

  logic       clk_pix = 1'b0;
  logic       rst_pix;
  logic       en;
  logic       test_pattern;
  logic       px_req;
  logic [2:0] px_x;
  logic [2:0] px_y;
  logic       frame_start;
  logic [4:0] r, g, b;
  logic [9:0] tmds0, tmds1, tmds2;

  vec_t tbl [NPOS];
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk_pix = ~clk_pix;

  smoldvi_video_core #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .RGB_BITS(5), .PIX_LATENCY(1)
  ) dut (
    .clk_pix     (clk_pix),
    .rst_pix     (rst_pix),
    .en          (en),
`ifdef SMOLDVI_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .px_req      (px_req),
    .px_x        (px_x),
    .px_y        (px_y),
    .frame_start (frame_start),
    .r           (r),
    .g           (g),
    .b           (b),
    .tmds0       (tmds0),
    .tmds1       (tmds1),
    .tmds2       (tmds2)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_px(input int k, input logic [4:0] vr, input logic [4:0] vg,
                        input logic [4:0] vb, input logic [9:0] e2,
                        input logic [9:0] e1, input logic [9:0] e0);
    tbl[k].r  = vr;
    tbl[k].g  = vg;
    tbl[k].b  = vb;
    tbl[k].e2 = e2;
    tbl[k].e1 = e1;
    tbl[k].e0 = e0;
  endtask

  // Blanking: green/red idle, blue carries {vsync,hsync} (both active-low)
  task automatic fill_table();
    int x, y;
    for (int k = 0; k < int'(NPOS); k++) begin
      x = k % 8;
      y = k / 8;
      tbl[k].r  = JUNK;
      tbl[k].g  = JUNK;
      tbl[k].b  = JUNK;
      tbl[k].e2 = C00;
      tbl[k].e1 = C00;
      if (y == 3) tbl[k].e0 = (x == 5 || x == 6) ? C00 : C01;
      else        tbl[k].e0 = (x == 5 || x == 6) ? C10 : C11;
    end
    // line 0: red 5'h10 (->0x84), green 0xFF, blue 0x00
    set_px(0,  5'h10, 5'h1F, 5'h00, 10'h17C, 10'h200, 10'h100);
    set_px(1,  5'h10, 5'h1F, 5'h00, 10'h383, 10'h0FF, 10'h3FF);
    set_px(2,  5'h10, 5'h1F, 5'h00, 10'h383, 10'h0FF, 10'h100);
    set_px(3,  5'h10, 5'h1F, 5'h00, 10'h383, 10'h200, 10'h3FF);
    // line 1: channels rotated
    set_px(8,  5'h00, 5'h10, 5'h1F, 10'h100, 10'h17C, 10'h200);
    set_px(9,  5'h00, 5'h10, 5'h1F, 10'h3FF, 10'h383, 10'h0FF);
    set_px(10, 5'h00, 5'h10, 5'h1F, 10'h100, 10'h383, 10'h0FF);
    set_px(11, 5'h00, 5'h10, 5'h1F, 10'h3FF, 10'h383, 10'h200);
  endtask

  // Cycle c = 0 is the first cycle after the DUT issues position (0,0)
  task automatic run_frames(input int ncyc);
    int k, x, y, j;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk_pix);
      k = c % int'(NPOS);
      x = k % 8;
      y = k / 8;
      check($sformatf("px_req[c=%0d]", c), 16'(px_req), 16'((x < 4) && (y < 2)));
      check($sformatf("frame_start[c=%0d]", c), 16'(frame_start), 16'(k == 0));
      check($sformatf("px_x[c=%0d]", c), 16'(px_x), 16'(x));
      check($sformatf("px_y[c=%0d]", c), 16'(px_y), 16'(y));
      if (c < 3) begin
        check($sformatf("tmds0_idle[c=%0d]", c), 16'(tmds0), 16'(C11));
        check($sformatf("tmds1_idle[c=%0d]", c), 16'(tmds1), 16'(C00));
        check($sformatf("tmds2_idle[c=%0d]", c), 16'(tmds2), 16'(C00));
      end else begin
        j = (c - 3) % int'(NPOS);
        check($sformatf("tmds0[pos=%0d]", j), 16'(tmds0), 16'(tbl[j].e0));
        check($sformatf("tmds1[pos=%0d]", j), 16'(tmds1), 16'(tbl[j].e1));
        check($sformatf("tmds2[pos=%0d]", j), 16'(tmds2), 16'(tbl[j].e2));
      end
      // data for the position issued last cycle is due in this cycle
      if (c >= 1) begin
        j = (c - 1) % int'(NPOS);
        r = tbl[j].r;
        g = tbl[j].g;
        b = tbl[j].b;
      end else begin
        r = JUNK;
        g = JUNK;
        b = JUNK;
      end
    end
  endtask

  task automatic check_parked(input string tag);
    check({tag, "_px_req"}, 16'(px_req), 16'(0));
    check({tag, "_frame_start"}, 16'(frame_start), 16'(0));
    check({tag, "_px_x"}, 16'(px_x), 16'(0));
    check({tag, "_px_y"}, 16'(px_y), 16'(0));
  endtask

  task automatic check_idle_syms(input string tag);
    check({tag, "_tmds0"}, 16'(tmds0), 16'(C11));
    check({tag, "_tmds1"}, 16'(tmds1), 16'(C00));
    check({tag, "_tmds2"}, 16'(tmds2), 16'(C00));
  endtask

  initial begin
    fill_table();
    rst_pix      = 1'b1;
    en           = 1'b1;
    test_pattern = 1'b0;
    r            = JUNK;
    g            = JUNK;
    b            = JUNK;
    repeat (2) @(negedge clk_pix);
    check_parked("reset");
    check_idle_syms("reset");

    // two full frames plus part of a third, crossing the (7,4)->(0,0) wrap
    rst_pix = 1'b0;
    run_frames(2 * int'(NPOS) + 12);

    // asynchronous reset mid-frame (in the middle of line 1)
    #2 rst_pix = 1'b1;
    #1;
    check_parked("midreset");
    check_idle_syms("midreset");
    @(negedge clk_pix);
    @(negedge clk_pix);
    rst_pix = 1'b0;
    run_frames(int'(NPOS) + 2);

    // drop en for 3 cycles mid-line with disparity non-zero
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_pix);
      check_parked($sformatf("en_low%0d", i));
    end
    en = 1'b1;
    run_frames(int'(NPOS) + 3);

`ifdef SMOLDVI_TEST_PATTERN_EN
    // bars at h=0..3 are 0,2,4,6: R=00,00,FF,FF G=00,FF,00,FF B=00 x4
    for (int y = 0; y < 2; y++) begin
      set_px(y*8 + 0, JUNK, JUNK, JUNK, 10'h100, 10'h100, 10'h100);
      set_px(y*8 + 1, JUNK, JUNK, JUNK, 10'h3FF, 10'h0FF, 10'h3FF);
      set_px(y*8 + 2, JUNK, JUNK, JUNK, 10'h200, 10'h3FF, 10'h100);
      set_px(y*8 + 3, JUNK, JUNK, JUNK, 10'h0FF, 10'h200, 10'h3FF);
    end
    en = 1'b0;
    repeat (3) @(negedge clk_pix);
    test_pattern = 1'b1;
    en = 1'b1;
    run_frames(int'(NPOS) + 3);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
